vx_dispatch_arb: RTL and testbench

Round-robin, credit-gated arbiter that shares one functional-unit execute port between `NUM_REQS` dispatch requesters (issue slots). It sits between the dispatch stage and a shared execution unit. Multi-packet instructions (sop..eop) keep the grant until their last packet fires. Each requester has a bounded number of instructions in flight, tracked by credit counters that the unit's commit path replenishes.

---
 rtl/vx_dispatch_arb.sv | 203 ++++++++++++++++++++
 tb/tb_vx_dispatch_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_arb.sv
// ---------------------------------------------------------------------------
// vx_dispatch_arb
// Round-robin, credit-gated arbiter that shares one execute port between
// NUM_REQS dispatch requesters. A multi-packet instruction (sop..eop) keeps
// the grant until its eop packet fires. A stalled grant is held until it
// fires. Each requester has MAX_CREDITS instructions in flight at most;
// credits are returned by the unit's commit path.
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NUM_REQS]          per-requester valid
//   req_data   in   [NUM_REQS][DATAW]   per-requester payload
//   req_eop    in   [NUM_REQS]          last packet of an instruction
//   req_ready  out  [NUM_REQS]          per-requester ready (one-hot or zero)
//   out_valid  out  1                   valid to execute port
//   out_data   out  [DATAW]             payload of granted requester
//   out_idx    out  [IDX_W]             index of granted requester
//   out_ready  in   1                   execute port ready
//   ret_valid  in   1                   credit return pulse
//   ret_idx    in   [IDX_W]             requester receiving the credit
//   busy       out  1                   some credit counter below MAX_CREDITS
// ---------------------------------------------------------------------------

// Flags a credit return that hits an already-full counter.
module vx_dispatch_arb_chk (
  input logic i_clk,
  input logic i_ret_sat
);

  // Overflowing return is a protocol error on the commit path.
  always @(posedge i_clk) begin
    assert (!i_ret_sat);
  end

endmodule

module vx_dispatch_arb #(
  parameter int NUM_REQS    = 4,
  parameter int DATAW       = 64,
  parameter int MAX_CREDITS = 4,
  localparam int IDX_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNT_W      = $clog2(MAX_CREDITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]            req_eop,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           out_valid,
  output logic [DATAW-1:0]               out_data,
  output logic [IDX_W-1:0]               out_idx,
  input  logic                           out_ready,
  input  logic                           ret_valid,
  input  logic [IDX_W-1:0]               ret_idx,
  output logic                           busy
);

  localparam logic [CNT_W-1:0] CRED_MAX  = CNT_W'(MAX_CREDITS);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQS - 1);

  logic [NUM_REQS-1:0][CNT_W-1:0] r_credits;
  logic [IDX_W-1:0]               r_last_grant;
  logic                           r_locked;
  logic [IDX_W-1:0]               r_lock_idx;
  logic                           r_held;
  logic [IDX_W-1:0]               r_held_idx;

  logic [NUM_REQS-1:0] w_elig;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_out_valid;
  logic                w_fire;
  logic [NUM_REQS-1:0] w_ready;
  logic [NUM_REQS-1:0] w_dec;
  logic [NUM_REQS-1:0] w_inc;
  logic                w_busy;
  logic                w_ret_sat;

  // First eligible index scanning upward from last+1, wrapping at NUM_REQS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQS-1:0] elig,
                                               input logic [IDX_W-1:0]    last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               c;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      c = int'(last) + 1 + k;
      if (c >= NUM_REQS) c = c - NUM_REQS;
      if (!found && elig[c]) begin
        found = 1'b1;
        pick  = IDX_W'(c);
      end
    end
    return pick;
  endfunction

  // Eligibility: a hold pins the stalled requester, a lock pins the
  // in-progress instruction (no credit check), otherwise valid && credit.
  always_comb begin
    w_elig = '0;
    if (r_held) begin
      w_elig[r_held_idx] = req_valid[r_held_idx];
    end else if (r_locked) begin
      w_elig[r_lock_idx] = req_valid[r_lock_idx];
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        w_elig[i] = req_valid[i] && (r_credits[i] != '0);
      end
    end
  end

  assign w_sel_idx   = rr_pick(w_elig, r_last_grant);
  // Nothing is offered while reset is asserted.
  assign w_out_valid = (|w_elig) && !reset;
  assign w_fire      = w_out_valid && out_ready;

  // Ready goes back only to the selected requester.
  always_comb begin
    w_ready = '0;
    if (w_out_valid) begin
      w_ready[w_sel_idx] = out_ready;
    end else begin
      w_ready = '0;
    end
  end

  // Per-requester credit consume (first packet only) and return strobes.
  always_comb begin
    w_dec     = '0;
    w_inc     = '0;
    w_busy    = 1'b0;
    w_ret_sat = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_dec[i]  = w_fire && !r_locked && (w_sel_idx == IDX_W'(i));
      w_inc[i]  = ret_valid && (ret_idx == IDX_W'(i));
      w_busy    = w_busy | (r_credits[i] != CRED_MAX);
      w_ret_sat = w_ret_sat | (w_inc[i] & ~w_dec[i] & (r_credits[i] == CRED_MAX));
    end
    w_ret_sat = w_ret_sat & ~reset;
  end

  // Credit counters: consume and return in the same cycle cancel out;
  // returns to a full counter saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        r_credits[i] <= CRED_MAX;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (w_dec[i] && !w_inc[i]) begin
          r_credits[i] <= r_credits[i] - CNT_W'(1);
        end else if (w_inc[i] && !w_dec[i] && (r_credits[i] != CRED_MAX)) begin
          r_credits[i] <= r_credits[i] + CNT_W'(1);
        end else begin
          r_credits[i] <= r_credits[i];
        end
      end
    end
  end

  // Round-robin pointer, multi-packet lock and stall hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= LAST_INIT;
      r_locked     <= 1'b0;
      r_lock_idx   <= '0;
      r_held       <= 1'b0;
      r_held_idx   <= '0;
    end else begin
      if (w_fire) begin
        r_held <= 1'b0;
        if (req_eop[w_sel_idx]) begin
          r_locked     <= 1'b0;
          // With a single requester there is nothing to rotate.
          r_last_grant <= (NUM_REQS > 1) ? w_sel_idx : IDX_W'(0);
        end else begin
          r_locked   <= 1'b1;
          r_lock_idx <= w_sel_idx;
        end
      end else if (w_out_valid) begin
        r_held     <= 1'b1;
        r_held_idx <= w_sel_idx;
      end else begin
        r_held <= r_held;
      end
    end
  end

  assign req_ready = w_ready;
  assign out_valid = w_out_valid;
  assign out_idx   = w_sel_idx;
  assign out_data  = req_data[w_sel_idx];
  assign busy      = w_busy;

  vx_dispatch_arb_chk u_chk (
    .i_clk     (clk),
    .i_ret_sat (w_ret_sat)
  );

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed bench for vx_dispatch_arb (NUM_REQS=4, MAX_CREDITS=2).
module tb_vx_dispatch_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MC = 2;
  localparam int IW = 2;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]      req_eop;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_idx;
  logic              out_ready;
  logic              ret_valid;
  logic [IW-1:0]     ret_idx;
  logic              busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  vx_dispatch_arb #(.NUM_REQS(N), .DATAW(DW), .MAX_CREDITS(MC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_eop   (req_eop),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .ret_valid (ret_valid),
    .ret_idx   (ret_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pay(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_eop   = 4'b1111;
    out_ready = 1'b1;
    ret_valid = 1'b0;
    ret_idx   = 2'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp1 [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) req_data[i] = pay(i);

    // Reset state
    reset = 1'b1; req_valid = 4'b1111; req_eop = 4'b1111;
    out_ready = 1'b1; ret_valid = 1'b0; ret_idx = 2'd0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Reset priority: 0,1,2,3,0
    req_valid = 4'b1111; req_eop = 4'b1111; out_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_idx",   64'(out_idx),   64'(exp1[k]));
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << exp1[k]));
      check("rr_data",  out_data,       pay(exp1[k]));
      tick();
    end

    // Credit exhaustion on req 2
    do_reset();
    req_valid = 4'b0100; #1;
    check("cx_fire1", 64'({out_valid, out_idx}), 64'({1'b1, 2'd2}));
    tick();
    check("cx_fire2", 64'({out_valid, out_idx}), 64'({1'b1, 2'd2}));
    tick();
    check("cx_empty_valid", 64'(out_valid), 64'd0);
    check("cx_empty_busy",  64'(busy),      64'd1);
    ret_valid = 1'b1; ret_idx = 2'd2;
    tick();
    ret_valid = 1'b0; #1;
    check("cx_ret_fire", 64'({out_valid, out_idx}), 64'({1'b1, 2'd2}));
    check("cx_ret_busy", 64'(busy), 64'd1);
    tick();

    // Multi-packet lock: 1,1,1,3,0
    do_reset();
    req_valid = 4'b0001; #1;
    check("mp_pre", 64'(out_idx), 64'd0);
    tick();
    req_valid = 4'b1011; req_eop = 4'b1101; #1;
    check("mp_p1", 64'(out_idx), 64'd1);
    tick();
    check("mp_p2", 64'(out_idx), 64'd1);
    check("mp_p2_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_eop = 4'b1111; #1;
    check("mp_p3", 64'(out_idx), 64'd1);
    tick();
    req_valid = 4'b1001; #1;
    check("mp_next3", 64'(out_idx), 64'd3);
    tick();
    check("mp_next0", 64'(out_idx), 64'd0);
    check("mp_cred1", 64'(dut.r_credits[1]), 64'd1);
    tick();

    // Stall hold on req 2
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b0; #1;
    check("sh_c1_idx",   64'(out_idx),   64'd2);
    check("sh_c1_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = 4'b0101; #1;
    check("sh_c2_idx",  64'(out_idx), 64'd2);
    check("sh_c2_data", out_data,     pay(2));
    tick();
    check("sh_c3_idx",  64'(out_idx), 64'd2);
    check("sh_c3_data", out_data,     pay(2));
    tick();
    out_ready = 1'b1; #1;
    check("sh_fire_idx",   64'({out_valid, out_idx}), 64'({1'b1, 2'd2}));
    check("sh_fire_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = 4'b0001; #1;
    check("sh_after", 64'(out_idx), 64'd0);
    tick();

    // Simultaneous return and grant
    do_reset();
    req_valid = 4'b0001; #1;
    tick();
    check("sim_pre_cred", 64'(dut.r_credits[0]), 64'd1);
    ret_valid = 1'b1; ret_idx = 2'd0; #1;
    check("sim_fire", 64'({out_valid, out_idx}), 64'({1'b1, 2'd0}));
    tick();
    ret_valid = 1'b0; req_valid = 4'b0000; #1;
    check("sim_cred", 64'(dut.r_credits[0]), 64'd1);

    // Reset while locked
    do_reset();
    req_valid = 4'b0011; req_eop = 4'b0010; #1;
    check("rl_p1", 64'(out_idx), 64'd0);
    tick();
    check("rl_locked", 64'(dut.r_locked), 64'd1);
    reset = 1'b1; #1;
    check("rl_rst_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0; req_eop = 4'b1111; #1;
    check("rl_unlocked", 64'(dut.r_locked), 64'd0);
    check("rl_credits",  64'(dut.r_credits), 64'(8'b1010_1010));
    check("rl_restart0", 64'(out_idx), 64'd0);
    tick();
    check("rl_restart1", 64'(out_idx), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
